// File: rtl/run_ctrl.sv
// ============================================================================
// Module      : run_ctrl
// Description : Load/run/unload sequencer: preloads CPU data memory, kicks the
//               CPU, times the run and streams back a result window.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module run_ctrl #(
    parameter int          LOAD_N   = 64,
    parameter int          RES_BASE = 64,
    parameter int          RES_N    = 32,
    parameter logic [15:0] MAX_CYC  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        mem_sel,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdat,
    input  logic [7:0]  mem_rdat,
    output logic        req,
    input  logic        done,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        fin,
    output logic        timeout,
    output logic [15:0] cyc_cnt
);

    localparam logic [7:0] LOAD_LAST = 8'(LOAD_N - 1);
    localparam logic [7:0] RES_LAST  = 8'(RES_N - 1);
    localparam logic [7:0] RES_BASE8 = 8'(RES_BASE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_REQ    = 3'd2,
        S_RUN    = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  idx_q;
    logic [15:0] cyc_q;
    logic [15:0] cyc_d;
    logic        to_q;
    logic        fin_q;

    assign cyc_d = cyc_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            cyc_q   <= 16'd0;
            to_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        idx_q   <= 8'd0;
                        cyc_q   <= 16'd0;
                        to_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        if (idx_q == LOAD_LAST) begin
                            state_q <= S_REQ;
                            idx_q   <= 8'd0;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                S_REQ: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cyc_q <= cyc_d;
                    // cyc_q is still zero in the first RUN cycle, masking a stale done
                    if (done && (cyc_q != 16'd0)) begin
                        state_q <= S_UNLOAD;
                    end else if (cyc_d == MAX_CYC) begin
                        to_q    <= 1'b1;
                        state_q <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (rd_ready) begin
                        if (idx_q == RES_LAST) begin
                            state_q <= S_IDLE;
                            idx_q   <= 8'd0;
                            fin_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ld_ready  = 1'b0;
        mem_sel   = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdat  = 8'd0;
        req       = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 8'd0;
        case (state_q)
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_sel   = 1'b1;
                mem_addr  = idx_q;
                mem_wdat  = ld_data;
                mem_wr_en = ld_valid;
            end
            S_REQ: begin
                req = 1'b1;
            end
            S_UNLOAD: begin
                mem_sel  = 1'b1;
                mem_addr = RES_BASE8 + idx_q;
                rd_valid = 1'b1;
                rd_data  = mem_rdat;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign fin     = fin_q;
    assign timeout = to_q;
    assign cyc_cnt = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ============================================================================
// Module      : tb_run_ctrl
// Description : Randomized scoreboard bench for run_ctrl with a cycle-level
//               reference model of the run phase and a behavioural memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_run_ctrl;

    localparam int          LOAD_N   = 4;
    localparam int          RES_BASE = 8;
    localparam int          RES_N    = 2;
    localparam logic [15:0] MAX_CYC  = 16'd10;

    logic        clk = 1'b0;
    logic        reset, start, ld_valid, done, rd_ready;
    logic [7:0]  ld_data;
    logic        ld_ready, mem_sel, mem_wr_en, req, rd_valid, busy, fin, timeout;
    logic [7:0]  mem_addr, mem_wdat, mem_rdat, rd_data;
    logic [15:0] cyc_cnt;

    run_ctrl #(
        .LOAD_N  (LOAD_N),
        .RES_BASE(RES_BASE),
        .RES_N   (RES_N),
        .MAX_CYC (MAX_CYC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .mem_sel  (mem_sel),
        .mem_wr_en(mem_wr_en),
        .mem_addr (mem_addr),
        .mem_wdat (mem_wdat),
        .mem_rdat (mem_rdat),
        .req      (req),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .busy     (busy),
        .fin      (fin),
        .timeout  (timeout),
        .cyc_cnt  (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Data memory; the CPU deposits its results when it sees req.
    logic [7:0] mem [256];
    logic [7:0] res_img [RES_N];
    assign mem_rdat = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_sel && mem_wr_en) mem[mem_addr] <= mem_wdat;
        if (req) begin
            for (int j = 0; j < RES_N; j++) mem[8'(RES_BASE + j)] <= res_img[j];
        end
    end

    int vec = 0;
    int mis = 0;
    logic [15:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [16:0] st_q[$];
    int          req_q[$];
    logic [15:0] last_cyc = 16'd0;
    logic        last_to  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run length from the rules: done counts from RUN cycle 2, the limit
    // applies on the cycle that makes the count reach MAX_CYC, done wins ties.
    function automatic logic [16:0] run_model(input int k, input bit stale);
        for (int i = 1; i <= int'(MAX_CYC); i++) begin
            if (i >= 2 && (stale || i > k)) return {1'b0, 16'(i)};
            if (i == int'(MAX_CYC)) return {1'b1, 16'(i)};
        end
        return 17'd0;
    endfunction

    // Monitor: pops and compares whenever the DUT presents an output event.
    initial begin : monitor
        logic [15:0] e;
        logic [16:0] s;
        logic [7:0]  prev_rd;
        bit          stall;
        stall = 1'b0;
        prev_rd = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                chk("wr_en_vs_handshake", 32'(mem_wr_en), 32'(ld_valid && ld_ready));
                if (mem_wr_en) begin
                    if (wr_q.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF);
                    else begin
                        e = wr_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e[15:8]));
                        chk("wr_data", 32'(mem_wdat), 32'(e[7:0]));
                    end
                end
                if (!mem_sel)
                    chk("unowned_outs", {13'd0, ld_ready, rd_valid, mem_wr_en, mem_addr, mem_wdat}, 32'd0);
                if (!busy) chk("idle_sel_req", {30'd0, mem_sel, req}, 32'd0);
                chk("ld_and_rd_exclusive", 32'(ld_ready && rd_valid), 32'd0);
                if (req) begin
                    if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else void'(req_q.pop_front());
                end
                if (stall) begin
                    chk("rd_hold_valid", 32'(rd_valid), 32'd1);
                    chk("rd_hold_data", 32'(rd_data), 32'(prev_rd));
                end
                if (rd_valid && rd_ready) begin
                    if (rd_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF);
                    else begin
                        e = rd_q.pop_front();
                        chk("rd_addr", 32'(mem_addr), 32'(e[15:8]));
                        chk("rd_data", 32'(rd_data), 32'(e[7:0]));
                    end
                end
                stall   = rd_valid && !rd_ready;
                prev_rd = rd_data;
                if (fin) begin
                    if (st_q.size() == 0) chk("unexpected_fin", 32'd1, 32'd0);
                    else begin
                        s = st_q.pop_front();
                        chk("fin_cyc_cnt", 32'(cyc_cnt), 32'(s[15:0]));
                        chk("fin_timeout", 32'(timeout), 32'(s[16]));
                        chk("fin_busy", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    // Called and returns at posedge+1; DUT expected in IDLE on entry.
    task automatic run_seq(input int k, input bit stale, input bit abort);
        logic [7:0]  ld [LOAD_N];
        logic [16:0] exp_st;
        int          j, b, n;
        bit          hs;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold_cyc", 32'(cyc_cnt), 32'(last_cyc));
        chk("idle_hold_to", 32'(timeout), 32'(last_to));
        for (int i = 0; i < LOAD_N; i++) begin
            ld[i] = 8'($urandom);
            wr_q.push_back({8'(i), ld[i]});
        end
        for (int i = 0; i < RES_N; i++) begin
            res_img[i] = 8'($urandom);
            rd_q.push_back({8'(RES_BASE + i), res_img[i]});
        end
        req_q.push_back(1);
        exp_st = run_model(k, stale);
        st_q.push_back(exp_st);
        done  = stale;
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cyc_clr", 32'(cyc_cnt), 32'd0);
        chk("start_to_clr", 32'(timeout), 32'd0);
        j = 0; b = 0;
        while (j < LOAD_N && b < 200) begin
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_data  = ld_valid ? ld[j] : 8'($urandom);
            start    = ($urandom_range(0, 2) == 0);
            @(negedge clk); hs = ld_valid && ld_ready;
            @(posedge clk); #1;
            if (hs) j++;
            b++;
        end
        ld_valid = 1'b0; start = 1'b0;
        chk("load_complete", 32'(j), 32'(LOAD_N));
        @(posedge clk); #1;
        for (int i = 1; i <= int'(exp_st[15:0]); i++) begin
            done  = stale || (i > k);
            start = ($urandom_range(0, 2) == 0);
            if (abort && i == 3) begin
                start = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("abort_outs", {12'd0, req, fin, busy, ld_ready, rd_valid, mem_wr_en, mem_sel, timeout, mem_addr, mem_wdat}, 32'd0);
                chk("abort_cyc", 32'(cyc_cnt), 32'd0);
                chk("abort_queues", 32'(wr_q.size() + req_q.size()), 32'd0);
                rd_q.delete(); st_q.delete();
                last_cyc = 16'd0; last_to = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n = 0; b = 0;
        while (n < RES_N && b < 200) begin
            rd_ready = (b < 3) ? 1'b0 : ($urandom_range(0, 2) != 0);
            start    = (n < RES_N - 1) && ($urandom_range(0, 2) == 0);
            @(negedge clk); hs = rd_valid && rd_ready;
            @(posedge clk); #1;
            if (hs) n++;
            b++;
        end
        rd_ready = 1'b0; start = 1'b0; done = 1'b0;
        chk("unload_complete", 32'(n), 32'(RES_N));
        @(posedge clk); #1;
        chk("seq_drained", 32'(wr_q.size() + rd_q.size() + st_q.size() + req_q.size()), 32'd0);
        last_cyc = exp_st[15:0];
        last_to  = exp_st[16];
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'd0;
        done = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        for (int i = 0; i < RES_N; i++) res_img[i] = 8'd0;
        #1;
        chk("reset_outs", {12'd0, req, fin, busy, ld_ready, rd_valid, mem_wr_en, mem_sel, timeout, mem_addr, mem_wdat}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        run_seq(5, 1'b0, 1'b0);    // done after 5 RUN cycles -> 6
        run_seq(0, 1'b1, 1'b0);    // stale done -> 2
        run_seq(99, 1'b0, 1'b0);   // timeout at 10
        run_seq(3, 1'b0, 1'b0);    // start clears timeout
        run_seq(9, 1'b0, 1'b0);    // done and limit coincide
        run_seq(99, 1'b0, 1'b1);   // reset mid-RUN
        run_seq(2, 1'b0, 1'b0);    // clean rerun after reset
        for (int s = 0; s < 20; s++)
            run_seq(int'($urandom_range(0, 12)), ($urandom_range(0, 4) == 0), 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=stuck required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
